// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: message type, magnitude saturation limit
// and the check-node FSM state encoding. Also used by the variable node stage.
package ldpc_pkg;

  localparam int MSG_W   = 8;
  localparam int MAG_MAX = (1 << (MSG_W - 1)) - 1;

  typedef logic signed [MSG_W-1:0] msg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } cnu_state_t;

endpackage

// File: rtl/cnu_min_track.sv
// Combinational next-state logic for the running first/second minimum and the
// column index of the first minimum. The registers live in cnu_serial.
module cnu_min_track #(
  parameter int MAG_W = 7,
  parameter int IDX_W = 3
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic [IDX_W-1:0] cnt_i,
  input  logic [MAG_W-1:0] min1_i,
  input  logic [MAG_W-1:0] min2_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [MAG_W-1:0] min1_o,
  output logic [MAG_W-1:0] min2_o,
  output logic [IDX_W-1:0] idx_o
);

  // Strict compares: a tie with min1 falls through to min2, so idx keeps the
  // first column that reached the minimum.
  always_comb begin
    min1_o = min1_i;
    min2_o = min2_i;
    idx_o  = idx_i;
    if (mag_i < min1_i) begin
      min2_o = min1_i;
      min1_o = mag_i;
      idx_o  = cnt_i;
    end else if (mag_i < min2_i) begin
      min2_o = mag_i;
    end
  end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit: collects DC q messages of one row, then
// streams DC r messages back with the row parity.
// Optional feature: define CNU_OFFSET_EN for offset min-sum (magnitude minus
// OFFSET, floored at zero); undefined gives plain min-sum.
//
// state      | meaning
// ST_IDLE    | just out of reset, arms COLLECT on the next edge
// ST_COLLECT | accepting q messages, tracking min1/min2/idx and signs
// ST_EMIT    | presenting r messages, one per out handshake
module cnu_serial
  import ldpc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DC     = 6,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic              out_last,
  output logic              parity
);

  localparam int MAG_W = DATA_W - 1;
  localparam int IDX_W = (DC > 1) ? $clog2(DC) : 1;
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(DC - 1);

  cnu_state_t        state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [MAG_W-1:0]  min1_q, min2_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DC-1:0]     sign_q;
  logic              sgn_all_q;
  logic              in_ready_q, out_valid_q, out_last_q, parity_q;
  logic [DATA_W-1:0] out_r_q;

  logic              in_fire, out_fire, q_sign, sgn_all_d;
  logic [DATA_W-1:0] q_neg;
  logic [MAG_W-1:0]  mag_d, min1_d, min2_d;
  logic [IDX_W-1:0]  idx_d, cnt_inc;
  logic [DC-1:0]     sign_d;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign q_sign    = in_q[DATA_W-1];
  assign q_neg     = -in_q;
  assign sgn_all_d = sgn_all_q ^ q_sign;
  assign cnt_inc   = cnt_q + IDX_W'(1);

  // Magnitude of the incoming q; the most negative code saturates to all-ones.
  always_comb begin
    mag_d = in_q[MAG_W-1:0];
    if (q_sign) begin
      mag_d = q_neg[DATA_W-1] ? '1 : q_neg[MAG_W-1:0];
    end
  end

  // Sign vector including the column being accepted this cycle, so r_0 can be
  // formed on the final q handshake.
  always_comb begin
    sign_d        = sign_q;
    sign_d[cnt_q] = q_sign;
  end

  cnu_min_track #(
    .MAG_W (MAG_W),
    .IDX_W (IDX_W)
  ) u_min_track (
    .mag_i  (mag_d),
    .cnt_i  (cnt_q),
    .min1_i (min1_q),
    .min2_i (min2_q),
    .idx_i  (idx_q),
    .min1_o (min1_d),
    .min2_o (min2_d),
    .idx_o  (idx_d)
  );

`ifndef CNU_OFFSET_EN
  localparam logic [31:0] OFFSET_BITS = OFFSET;
  logic unused_offset;
  assign unused_offset = ^OFFSET_BITS;
`endif

  function automatic logic [DATA_W-1:0] r_calc(
    input logic [IDX_W-1:0] col,
    input logic [MAG_W-1:0] m1,
    input logic [MAG_W-1:0] m2,
    input logic [IDX_W-1:0] idx,
    input logic             sgn_all,
    input logic [DC-1:0]    signs
  );
    logic [MAG_W-1:0]  m;
    logic [DATA_W-1:0] v;
    m = (col == idx) ? m2 : m1;
`ifdef CNU_OFFSET_EN
    m = (m > MAG_W'(OFFSET)) ? (m - MAG_W'(OFFSET)) : '0;
`endif
    v = {1'b0, m};
    return (sgn_all ^ signs[col]) ? -v : v;
  endfunction

  // Frame FSM with all handshake/output registers; mins are re-armed whenever
  // COLLECT is (re)entered so no state leaks between rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      min1_q      <= '1;
      min2_q      <= '1;
      idx_q       <= '0;
      sign_q      <= '0;
      sgn_all_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_last_q  <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_COLLECT;
          in_ready_q <= 1'b1;
          cnt_q      <= '0;
          min1_q     <= '1;
          min2_q     <= '1;
          idx_q      <= '0;
          sgn_all_q  <= 1'b0;
        end
        ST_COLLECT: begin
          if (in_fire) begin
            sign_q    <= sign_d;
            min1_q    <= min1_d;
            min2_q    <= min2_d;
            idx_q     <= idx_d;
            sgn_all_q <= sgn_all_d;
            if (cnt_q == LAST_COL) begin
              state_q     <= ST_EMIT;
              cnt_q       <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_r_q     <= r_calc('0, min1_d, min2_d, idx_d, sgn_all_d, sign_d);
              out_last_q  <= 1'b0;
              parity_q    <= sgn_all_d;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_EMIT: begin
          if (out_fire) begin
            if (cnt_q == LAST_COL) begin
              state_q     <= ST_COLLECT;
              cnt_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              min1_q      <= '1;
              min2_q      <= '1;
              idx_q       <= '0;
              sgn_all_q   <= 1'b0;
            end else begin
              cnt_q      <= cnt_inc;
              out_r_q    <= r_calc(cnt_inc, min1_q, min2_q, idx_q, sgn_all_q, sign_q);
              out_last_q <= (cnt_inc == LAST_COL);
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_last  = out_last_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial with DATA_W=8, DC=6, OFFSET=1.
module tb_cnu_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_q = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_r;
  logic       out_last;
  logic       parity;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cnu_serial #(.DATA_W(8), .DC(6), .OFFSET(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_last  (out_last),
    .parity    (parity)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int r_val();
    logic signed [7:0] s;
    s = out_r;
    return int'(s);
  endfunction

  task automatic send_one(input int v, input string tag);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_q     = 8'(v);
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check({tag, " in_ready timeout"}, int'(in_ready), 1);
    @(posedge clk);
  endtask

  task automatic send_frame(input int q[6], input string tag);
    for (int i = 0; i < 6; i++) send_one(q[i], tag);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " out_valid after last q"}, int'(out_valid), 1);
  endtask

  task automatic recv_frame(input int exp[6], input int par, input int stall_at,
                            input string tag);
    int budget;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_q      = 8'd99;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("%s stall%0d r", tag, k), r_val(), exp[i]);
          check($sformatf("%s stall%0d out_valid", tag, k), int'(out_valid), 1);
          check($sformatf("%s stall%0d in_ready", tag, k), int'(in_ready), 0);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      budget = 0;
      while (!out_valid && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!out_valid) check($sformatf("%s out_valid timeout r%0d", tag, i), int'(out_valid), 1);
      check($sformatf("%s r%0d", tag, i), r_val(), exp[i]);
      check($sformatf("%s last%0d", tag, i), int'(out_last), (i == 5) ? 1 : 0);
      check($sformatf("%s parity%0d", tag, i), int'(parity), par);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after last"}, int'(in_ready), 1);
    check({tag, " out_valid after last"}, int'(out_valid), 0);
  endtask

  int q_basic[6], q_sat[6], q_ties[6], q_zero[6];
  int e_basic[6], e_sat[6], e_ties[6], e_zero[6];

  initial begin
    q_basic = '{5, -3, 7, 2, -9, 4};
    q_sat   = '{-128, 127, 127, 127, 127, 127};
    q_ties  = '{4, 4, 10, 10, 10, 10};
    q_zero  = '{0, 0, 0, 0, 0, 0};
`ifdef CNU_OFFSET_EN
    e_basic = '{1, -1, 1, 2, -1, 1};
    e_sat   = '{126, -126, -126, -126, -126, -126};
    e_ties  = '{3, 3, 3, 3, 3, 3};
`else
    e_basic = '{2, -2, 2, 3, -2, 2};
    e_sat   = '{127, -127, -127, -127, -127, -127};
    e_ties  = '{4, 4, 4, 4, 4, 4};
`endif
    e_zero  = '{0, 0, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("rst in_ready", int'(in_ready), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_r", int'(out_r), 0);
    check("rst out_last", int'(out_last), 0);
    check("rst parity", int'(parity), 0);
    rst_n = 1'b1;

    send_frame(q_basic, "basic");
    recv_frame(e_basic, 0, -1, "basic");

    send_frame(q_sat, "sat");
    recv_frame(e_sat, 1, -1, "sat");

    send_frame(q_ties, "ties");
    recv_frame(e_ties, 0, -1, "ties");

    send_frame(q_basic, "bp");
    recv_frame(e_basic, 0, 2, "bp");

    send_frame(q_ties, "post_bp");
    recv_frame(e_ties, 0, -1, "post_bp");

    send_one(1, "abort");
    send_one(-1, "abort");
    send_one(1, "abort");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst in_ready", int'(in_ready), 0);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst parity", int'(parity), 0);
    rst_n = 1'b1;
    send_frame(q_basic, "after_rst");
    recv_frame(e_basic, 0, -1, "after_rst");

    send_frame(q_zero, "zero");
    recv_frame(e_zero, 0, -1, "zero");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
